// File: rtl/wb_pkg.sv
// Shared write-back types: widths and the request payload carried by the ALU,
// LSU and the load buffer.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_lsu_fifo.sv
// Small FIFO of load results waiting for a free register-file write slot.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of two.
module wb_lsu_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  wb_req_t                      push_req_i,
    input  logic                         pop_i,
    output wb_req_t                      head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t        mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_req_i;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results into one registered
// register-file write per cycle and tracks pending destinations for RAW checks.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        chk_rs1,
    input  logic [4:0]        chk_rs2,
    output logic              hazard,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [4:0]        lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [NREG-1:0]   pending
);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    // Handshake: a transfer fires at the rising edge when valid && ready; the
    // producer holds its payload stable while valid && !ready.

    wb_req_t          alu_req, lsu_req, fifo_head, win_req;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             sel_alu, sel_lsu, do_write;

    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]  pending_q, pending_d;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign lsu_req = '{rd: lsu_rd, data: lsu_data};

    wb_lsu_fifo #(.DEPTH(LQ_DEPTH)) u_lsu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (lsu_valid && lsu_ready),
        .push_req_i (lsu_req),
        .pop_i      (sel_lsu),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // A full buffer takes priority so loads cannot starve behind a busy ALU.
    assign lsu_ready = (fifo_count < CW'(LQ_DEPTH));
    assign alu_ready = !fifo_full;
    assign sel_alu   = alu_valid && !fifo_full;
    assign sel_lsu   = fifo_full || (!alu_valid && !fifo_empty);
    assign win_req   = sel_lsu ? fifo_head : alu_req;
    assign do_write  = (sel_alu || sel_lsu) && (win_req.rd != '0);

    always_comb begin
        rf_we_d    = do_write;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pending_d  = pending_q;
        if (do_write) begin
            rf_waddr_d            = win_req.rd;
            rf_wdata_d            = win_req.data;
            pending_d[win_req.rd] = 1'b0;
        end
        // Set after clear: a fresh reservation outlives the retiring write.
        if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;
    assign hazard   = pending_q[chk_rs1] | pending_q[chk_rs2];
endmodule
